// File: rtl/tristate_bus_pkg.sv
// ---------------------------------------------------------------------------
// tristate_bus_pkg
//
// Shared definitions for the shared tristate bus controller.
//
// Contents:
//   state_t   - controller phase: IDLE (bus released, no owner),
//               DRIVE (one channel owns and drives the bus),
//               TURN (bus released between two owners)
//   cnt_width - width of a counter that must hold the values 0..max_val.
//               Never returns less than one bit, so a counter is always
//               at least one bit wide.
// ---------------------------------------------------------------------------
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tristate_bus_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin picker. The search starts at the channel
// just above last_owner and wraps around, so the previous owner is the very
// last candidate. A channel that has just used up its hold time can
// therefore only win again when nobody else is asking.
//
// Parameters:
//   N_CH   number of channels
//   IDX_W  width of a channel index
//
// Ports:
//   req         in   N_CH   request vector
//   last_owner  in   IDX_W  index of the most recent owner
//   winner      out  N_CH   one-hot winner, all-zero when nobody requests
//   winner_idx  out  IDX_W  index of the winner (0 when nobody requests)
//   any_req     out  1      at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N_CH-1:0]  winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any_req
);

  always_comb begin
    logic found;
    int   cand;
    // NOTE: every variable assigned in this block gets a value before any
    // conditional code, so no path can leave it holding its old value and
    // no latch is inferred.
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    // Walk the channels in rotation order; the first requester found wins.
    for (int k = 1; k <= N_CH; k++) begin
      cand = (int'(last_owner) + k) % N_CH;
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = IDX_W'(cand);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/tristate_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tristate_bus_ctrl
//
// Lets N_CH channels share one WIDTH-bit tristate bus. A round-robin
// arbiter hands the bus to one channel at a time; the owner's data is
// driven under a registered output enable for at most MAX_HOLD cycles,
// and the bus is released to Z for TURN_CYC cycles between owners so two
// drivers never overlap. The bus is sampled into bus_rd every cycle, so an
// external driver can be read back while the bus is released.
//
// Parameters:
//   N_CH      number of requesting channels (2..8)
//   WIDTH     bus/data width in bits (1..32)
//   TURN_CYC  released cycles between consecutive owners (1..15)
//   MAX_HOLD  maximum consecutive drive cycles per grant (1..255)
//
// Ports:
//   clk     in     1           rising-edge clock
//   rst     in     1           asynchronous, active-high reset
//   req     in     N_CH        per-channel bus request
//   din     in     N_CH*WIDTH  channel data, channel i at din[i*WIDTH +: WIDTH]
//   bus     inout  WIDTH       shared bus, driven only while bus_oe=1
//   grant   out    N_CH        one-hot owner, all-zero when no owner
//   bus_oe  out    1           registered output enable, equals |grant
//   bus_rd  out    WIDTH       bus sampled at every rising edge
//   busy    out    1           high while driving or turning around
// ---------------------------------------------------------------------------
module tristate_bus_ctrl
  import tristate_bus_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0]      bus,
  output logic [N_CH-1:0]       grant,
  output logic                  bus_oe,
  output logic [WIDTH-1:0]      bus_rd,
  output logic                  busy
);

  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W  = cnt_width(MAX_HOLD);
  localparam int TURN_W = cnt_width(TURN_CYC);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(MAX_HOLD);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC);
  localparam logic [IDX_W-1:0]  LAST_CH   = IDX_W'(N_CH - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_q,  state_d;
  logic [IDX_W-1:0]    owner_q,  owner_d;
  logic [IDX_W-1:0]    last_q,   last_d;
  logic [CNT_W-1:0]    hold_q,   hold_d;
  logic [TURN_W-1:0]   turn_q,   turn_d;
  logic [N_CH-1:0]     grant_q,  grant_d;
  logic                oe_q,     oe_d;

  // Arbiter results
  logic [N_CH-1:0]     arb_winner;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  logic [WIDTH-1:0]    sel_data;

  // The search starts after the most recent owner, which only changes when
  // a drive phase ends, so it is stable across IDLE and TURN.
  rr_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .last_owner (last_q),
    .winner     (arb_winner),
    .winner_idx (arb_idx),
    .any_req    (arb_any)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    grant_d = grant_q;
    oe_d    = oe_q;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = DRIVE;
          owner_d = arb_idx;
          grant_d = arb_winner;
          oe_d    = 1'b1;
          hold_d  = CNT_W'(1);
        end
      end

      DRIVE: begin
        // Release when the owner stops asking or its hold time is used up.
        if (!req[owner_q] || (hold_q == HOLD_LAST)) begin
          state_d = TURN;
          grant_d = '0;
          oe_d    = 1'b0;
          last_d  = owner_q;
          hold_d  = '0;
          turn_d  = TURN_W'(1);
        end else begin
          hold_d  = hold_q + CNT_W'(1);
        end
      end

      TURN: begin
        if (turn_q == TURN_LAST) begin
          turn_d = '0;
          // last_q already names the owner that just left, so it is the
          // final candidate in this arbitration.
          if (arb_any) begin
            state_d = DRIVE;
            owner_d = arb_idx;
            grant_d = arb_winner;
            oe_d    = 1'b1;
            hold_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        oe_d    = 1'b0;
        hold_d  = '0;
        turn_d  = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_CH;
      hold_q  <= '0;
      turn_q  <= '0;
      grant_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before the edge, independent of statement order.
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      grant_q <= grant_d;
      oe_q    <= oe_d;
    end
  end

  // Readback register: samples whatever is on the bus, ours or external.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rd <= '0;
    end else begin
      bus_rd <= bus;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs and tristate drive
  // -------------------------------------------------------------------------
  assign grant  = grant_q;
  assign bus_oe = oe_q;
  assign busy   = (state_q != IDLE);

  // Data path is combinational from din so the owner's data changes appear
  // on the bus within the same cycle. The enable is a flop cleared by the
  // asynchronous reset, so reset releases the bus without waiting for a clock.
  assign sel_data = din[owner_q*WIDTH +: WIDTH];
  assign bus      = bus_oe ? sel_data : {WIDTH{1'bz}};

endmodule
